// File: rtl/control_sequencer_pkg.sv
// Shared types for the simple-viii microcode sequencer: datapath control word,
// ALU flags, microword format and sequencer states.
package control_sequencer_pkg;

  typedef enum logic [2:0] {
    ALUNOP, ALUADD, ALUSUB, ALUAND, ALUOR, ALUXOR, ALUSHL, ALUSHR
  } alu_op_e;

  typedef enum logic {READ, WRITE} mem_op_e;

  typedef enum logic [1:0] {REG_A, REG_B, REG_C, REG_D} reg_sel_e;

  typedef enum logic {SRC_ALU, SRC_MEM} wb_src_e;

  typedef struct packed {
    alu_op_e  alu_op;
    mem_op_e  mem_op;
    reg_sel_e rd;
    reg_sel_e rs1;
    reg_sel_e rs2;
    wb_src_e  wb_src;
    logic     reg_we;
    logic     mem_en;
    logic     pc_inc;
    logic     halt;
    logic     next_instr;
    logic     reset;
  } control_word_t;

  typedef struct packed {
    logic alu_zero;
    logic alu_carry;
  } alu_flag_t;

  typedef enum logic [1:0] {COND_NONE, COND_Z, COND_NZ, COND_C} ucond_e;

  typedef struct packed {
    ucond_e        cond;
    control_word_t cw;
  } uword_t;

  typedef enum logic [1:0] {SEQ_FETCH, SEQ_EXEC, SEQ_HALT} seq_state_e;

  function automatic logic cond_true(input ucond_e cond, input alu_flag_t flags);
    logic hit;
    hit = 1'b0;
    case (cond)
      COND_Z:  hit = flags.alu_zero;
      COND_NZ: hit = ~flags.alu_zero;
      COND_C:  hit = flags.alu_carry;
      default: hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/control_sequencer.sv
// Microcode sequencer: fetches an opcode, walks its microprogram in an external
// ROM and registers each microword's control word onto the datapath bus.
//
// state     | meaning
// SEQ_FETCH | waiting for a valid instruction byte, control word is NOP
// SEQ_EXEC  | issuing microwords for the opcode held in IR
// SEQ_HALT  | stopped until a resume pulse, control word is NOP
module control_sequencer
  import control_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int OPCODE_WIDTH = 4,
  parameter int STEP_WIDTH   = 3,
  localparam int UADDR_WIDTH = OPCODE_WIDTH + STEP_WIDTH
) (
  input  logic                   ClkxCI,
  input  logic                   RstxRI,
  input  logic [DATA_WIDTH-1:0]  InstrxDI,
  input  logic                   InstrValidxSI,
  input  alu_flag_t              FlagsxDI,
  input  uword_t                 UWordxDI,
  input  logic                   ResumexSI,
  output logic [UADDR_WIDTH-1:0] UAddrxDO,
  output control_word_t          ControlWordxDO,
  output logic                   FetchReqxSO,
  output logic                   HaltedxSO,
  output logic                   StepOvfxSO
);

  seq_state_e                state_q;
  logic [OPCODE_WIDTH-1:0]   ir_q;
  logic [STEP_WIDTH-1:0]     step_q;
  control_word_t             cw_q;
  logic                      fetch_req_q;
  logic                      halted_q;
  logic                      ovf_q;

  // One extra bit so that running past the last step is visible as a carry.
  logic [STEP_WIDTH:0]       step_d;
  logic [STEP_WIDTH:0]       step_inc;

  always_comb begin
    step_inc = cond_true(UWordxDI.cond, FlagsxDI) ? (STEP_WIDTH+1)'(2) : (STEP_WIDTH+1)'(1);
    step_d   = {1'b0, step_q} + step_inc;
  end

  always_ff @(posedge ClkxCI) begin
    if (RstxRI) begin
      state_q     <= SEQ_FETCH;
      ir_q        <= '0;
      step_q      <= '0;
      cw_q        <= '0;
      fetch_req_q <= 1'b1;
      halted_q    <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      case (state_q)
        SEQ_FETCH: begin
          cw_q <= '0;
          if (InstrValidxSI) begin
            ir_q        <= InstrxDI[DATA_WIDTH-1 -: OPCODE_WIDTH];
            step_q      <= '0;
            state_q     <= SEQ_EXEC;
            fetch_req_q <= 1'b0;
          end
        end
        SEQ_EXEC: begin
          cw_q <= UWordxDI.cw;
          if (UWordxDI.cw.reset) begin
            // Soft reset: the reset word itself is never driven to the datapath.
            state_q     <= SEQ_FETCH;
            ir_q        <= '0;
            step_q      <= '0;
            cw_q        <= '0;
            fetch_req_q <= 1'b1;
            halted_q    <= 1'b0;
            ovf_q       <= 1'b0;
          end else if (UWordxDI.cw.halt) begin
            state_q  <= SEQ_HALT;
            halted_q <= 1'b1;
          end else if (UWordxDI.cw.next_instr) begin
            state_q     <= SEQ_FETCH;
            fetch_req_q <= 1'b1;
          end else if (step_d[STEP_WIDTH]) begin
            state_q     <= SEQ_FETCH;
            step_q      <= '0;
            fetch_req_q <= 1'b1;
            ovf_q       <= 1'b1;
          end else begin
            step_q <= step_d[STEP_WIDTH-1:0];
          end
        end
        SEQ_HALT: begin
          cw_q <= '0;
          if (ResumexSI) begin
            state_q     <= SEQ_FETCH;
            fetch_req_q <= 1'b1;
            halted_q    <= 1'b0;
          end
        end
        default: begin
          state_q     <= SEQ_FETCH;
          cw_q        <= '0;
          fetch_req_q <= 1'b1;
          halted_q    <= 1'b0;
        end
      endcase
    end
  end

  // Operand bits below the opcode field are consumed by the datapath, not here.
  generate
    if (DATA_WIDTH > OPCODE_WIDTH) begin : g_unused_instr
      logic unused_instr_bits;
      assign unused_instr_bits = ^InstrxDI[DATA_WIDTH-OPCODE_WIDTH-1:0];
    end
  endgenerate

  assign UAddrxDO       = {ir_q, step_q};
  assign ControlWordxDO = cw_q;
  assign FetchReqxSO    = fetch_req_q;
  assign HaltedxSO      = halted_q;
  assign StepOvfxSO     = ovf_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: directed microprograms plus random
// microcode, checked against an instruction-level trace predictor.
module tb_control_sequencer;
  import control_sequencer_pkg::*;

  localparam int O_FETCH = 0;
  localparam int O_HALT  = 1;
  localparam int O_OVF   = 2;
  localparam int O_RST   = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    instr;
  logic          valid;
  alu_flag_t     flags;
  uword_t        uword;
  logic          resume;
  logic [6:0]    uaddr;
  control_word_t cw;
  logic          fetch_req;
  logic          halted;
  logic          ovf;

  uword_t        rom [0:127];
  logic [6:0]    trace [$];
  int            outcome;
  int            total = 0;
  int            bad = 0;
  logic          exp_ovf = 1'b0;

  always #5 clk = ~clk;

  assign uword = rom[uaddr];

  control_sequencer dut (
    .ClkxCI         (clk),
    .RstxRI         (rst),
    .InstrxDI       (instr),
    .InstrValidxSI  (valid),
    .FlagsxDI       (flags),
    .UWordxDI       (uword),
    .ResumexSI      (resume),
    .UAddrxDO       (uaddr),
    .ControlWordxDO (cw),
    .FetchReqxSO    (fetch_req),
    .HaltedxSO      (halted),
    .StepOvfxSO     (ovf)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic uword_t mk(input ucond_e c, input logic h, input logic n, input logic r);
    uword_t w;
    w = '0;
    w.cond          = c;
    w.cw.alu_op     = alu_op_e'($urandom_range(1, 7));
    w.cw.mem_op     = mem_op_e'($urandom_range(0, 1));
    w.cw.rd         = reg_sel_e'($urandom_range(0, 3));
    w.cw.rs1        = reg_sel_e'($urandom_range(0, 3));
    w.cw.rs2        = reg_sel_e'($urandom_range(0, 3));
    w.cw.wb_src     = wb_src_e'($urandom_range(0, 1));
    w.cw.reg_we     = 1'b1;
    w.cw.mem_en     = 1'($urandom_range(0, 1));
    w.cw.pc_inc     = 1'($urandom_range(0, 1));
    w.cw.halt       = h;
    w.cw.next_instr = n;
    w.cw.reset      = r;
    return w;
  endfunction

  function automatic uword_t rnd_word();
    int r;
    r = $urandom_range(0, 99);
    return mk(ucond_e'($urandom_range(0, 3)), r < 8, (r < 4) || (r >= 8 && r < 33), r >= 96);
  endfunction

  // Walk the microprogram of one opcode the way the sequencer is described:
  // record every address issued and how the instruction ends.
  task automatic predict(input logic [3:0] op, input logic zf, input logic cf);
    int     s;
    int     adv;
    logic   hit;
    uword_t w;
    trace.delete();
    s = 0;
    forever begin
      trace.push_back({op, 3'(s)});
      w = rom[{op, 3'(s)}];
      if (w.cw.reset)      begin outcome = O_RST;   return; end
      if (w.cw.halt)       begin outcome = O_HALT;  return; end
      if (w.cw.next_instr) begin outcome = O_FETCH; return; end
      hit = (w.cond == COND_Z && zf) || (w.cond == COND_NZ && !zf) || (w.cond == COND_C && cf);
      adv = hit ? 2 : 1;
      if (s + adv > 7) begin outcome = O_OVF; return; end
      s = s + adv;
    end
  endtask

  task automatic run_instr(input logic [3:0] op, input logic zf, input logic cf, input logic poke_resume);
    control_word_t prev;
    predict(op, zf, cf);
    flags = '{alu_zero: zf, alu_carry: cf};
    check("fetch_req_before", fetch_req, 1);
    instr = {op, 4'($urandom)};
    valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    instr = 8'($urandom);
    check("fetch_req_exec", fetch_req, 0);
    check("halted_exec", halted, 0);
    prev = '0;
    for (int i = 0; i < trace.size(); i++) begin
      check("uaddr", uaddr, trace[i]);
      check("cw_lag", 32'(cw), 32'(prev));
      prev = rom[trace[i]].cw;
      if (poke_resume && i == 0) resume = 1'b1;
      @(posedge clk); #1;
      resume = 1'b0;
    end
    case (outcome)
      O_RST: begin
        exp_ovf = 1'b0;
        check("rst_cw", 32'(cw), 0);
        check("rst_uaddr", uaddr, 0);
        check("rst_fetch_req", fetch_req, 1);
        check("rst_ovf", ovf, 0);
      end
      O_HALT: begin
        check("halt_cw_last", 32'(cw), 32'(prev));
        check("halt_flag", halted, 1);
        check("halt_fetch_req", fetch_req, 0);
        for (int k = 0; k < 5; k++) begin
          @(posedge clk); #1;
          check("halt_cw_nop", 32'(cw), 0);
          check("halt_hold", halted, 1);
        end
        resume = 1'b1;
        @(posedge clk); #1;
        resume = 1'b0;
        check("resume_halted", halted, 0);
        check("resume_fetch_req", fetch_req, 1);
        check("resume_cw", 32'(cw), 0);
      end
      default: begin
        if (outcome == O_OVF) exp_ovf = 1'b1;
        check("end_cw_last", 32'(cw), 32'(prev));
        check("end_fetch_req", fetch_req, 1);
        check("end_halted", halted, 0);
      end
    endcase
    check("ovf_sticky", ovf, exp_ovf);
  endtask

  initial begin
    rst = 1'b1; valid = 1'b0; resume = 1'b0; instr = '0; flags = '0;
    for (int a = 0; a < 128; a++) rom[a] = rnd_word();
    // op 2: three plain steps
    rom[7'h10] = mk(COND_NONE, 0, 0, 0);
    rom[7'h11] = mk(COND_NONE, 0, 0, 0);
    rom[7'h12] = mk(COND_NONE, 0, 1, 0);
    // op 3 / op 4: conditional skip on Z / NZ at step 1
    rom[7'h18] = mk(COND_NONE, 0, 0, 0);
    rom[7'h19] = mk(COND_Z,    0, 0, 0);
    rom[7'h1A] = mk(COND_NONE, 0, 1, 0);
    rom[7'h1B] = mk(COND_NONE, 0, 1, 0);
    rom[7'h20] = mk(COND_NONE, 0, 0, 0);
    rom[7'h21] = mk(COND_NZ,   0, 0, 0);
    rom[7'h22] = mk(COND_NONE, 0, 1, 0);
    rom[7'h23] = mk(COND_NONE, 0, 1, 0);
    // op 5: halt together with next_instr
    rom[7'h28] = mk(COND_NONE, 1, 1, 0);
    // op 6: eight plain steps, runs off the end
    for (int s = 0; s < 8; s++) rom[7'h30 + s] = mk(COND_NONE, 0, 0, 0);
    // op 7: soft reset at step 1
    rom[7'h38] = mk(COND_NONE, 0, 0, 0);
    rom[7'h39] = mk(COND_NONE, 0, 0, 1);
    rom[7'h3A] = mk(COND_NONE, 0, 1, 0);
    // op 8: long plain program used for the hard reset case
    for (int s = 0; s < 8; s++) rom[7'h40 + s] = mk(COND_NONE, 0, s == 3, 0);
    // op 9: carry-conditional skip at step 6 overflows via step+2
    for (int s = 0; s < 6; s++) rom[7'h48 + s] = mk(COND_NONE, 0, 0, 0);
    rom[7'h4E] = mk(COND_C,    0, 0, 0);
    rom[7'h4F] = mk(COND_NONE, 0, 1, 0);

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_fetch_req", fetch_req, 1);
    check("reset_halted", halted, 0);
    check("reset_ovf", ovf, 0);
    check("reset_uaddr", uaddr, 0);
    check("reset_cw", 32'(cw), 0);

    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("idle_fetch_req", fetch_req, 1);
      check("idle_cw", 32'(cw), 0);
    end

    run_instr(4'h2, 0, 0, 1);
    run_instr(4'h3, 1, 0, 0);
    run_instr(4'h3, 0, 0, 0);
    run_instr(4'h4, 1, 0, 0);
    run_instr(4'h4, 0, 0, 0);
    run_instr(4'h5, 0, 0, 0);
    run_instr(4'h6, 0, 0, 0);
    run_instr(4'h2, 1, 1, 0);
    run_instr(4'h9, 0, 0, 0);
    run_instr(4'h9, 0, 1, 0);
    run_instr(4'h7, 0, 0, 0);
    run_instr(4'h6, 1, 0, 0);

    // hard reset while step 1 is on the address bus
    flags = '0;
    instr = 8'h80;
    valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    @(posedge clk); #1;
    check("hrst_uaddr_step1", uaddr, 7'h41);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_ovf = 1'b0;
    check("hrst_cw", 32'(cw), 0);
    check("hrst_uaddr", uaddr, 0);
    check("hrst_fetch_req", fetch_req, 1);
    check("hrst_halted", halted, 0);
    check("hrst_ovf", ovf, 0);
    @(posedge clk); #1;
    check("hrst_no_step2", 32'(cw), 0);
    check("hrst_hold_fetch", fetch_req, 1);

    for (int n = 0; n < 60; n++)
      run_instr(4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
